// File: rtl/sd_dac_pkg.sv
// Shared state encoding, modulator constants and parameter-legality check
// for the time-multiplexed sigma-delta DAC.
package sd_dac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Full-scale feedback magnitude.
    function automatic longint delta(input int in_w);
        return longint'(1) << (in_w - 1);
    endfunction

    // Largest input magnitude admitted into the modulator.
    function automatic longint clamp_lim(input int in_w);
        return longint'(1) << (in_w - 2);
    endfunction

    function automatic bit params_legal(input int nch, input int in_w,
                                        input int acc_w, input int order);
        return (nch >= 1) && (nch <= 16) && (in_w >= 2) &&
               (acc_w >= in_w + 4) && (acc_w <= 64) &&
               ((order == 1) || (order == 2));
    endfunction

endpackage

// File: rtl/sd_dac_clamp.sv
// Capture-path conditioning of one sample: mute, clamp to +/-2^(IN_W-2),
// then sign-extend to the integrator width.
module sd_dac_clamp import sd_dac_pkg::*; #(
    parameter int IN_W  = 18,
    parameter int ACC_W = 48
) (
    input  logic signed [IN_W-1:0]  sample,
    input  logic                    mute,
    output logic signed [ACC_W-1:0] value
);

    localparam logic signed [IN_W-1:0] LIM = IN_W'(clamp_lim(IN_W));

    logic signed [IN_W-1:0] clamped;

    // The top two bits disagreeing with each other mark |sample| >= LIM.
    always_comb begin
        clamped = sample;
        if (mute)
            clamped = '0;
        else if (sample[IN_W-1:IN_W-2] == 2'b01)
            clamped = LIM;
        else if (sample[IN_W-1:IN_W-2] == 2'b10)
            clamped = -LIM;
    end

    assign value = {{(ACC_W-IN_W){clamped[IN_W-1]}}, clamped};

endmodule

// File: rtl/sigma_delta_multich_dac.sv
// Multichannel 1st/2nd-order sigma-delta DAC sharing one three-operand adder
// across all channels and integrators, with a one-deep pending-frame buffer.
module sigma_delta_multich_dac import sd_dac_pkg::*; #(
    parameter int NCH   = 2,
    parameter int IN_W  = 18,
    parameter int ACC_W = 48,
    parameter int ORDER = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*IN_W-1:0] sample_in,
    input  logic              sample_in_rdy,
    input  logic              mute,
    output logic [NCH-1:0]    dout,
    output logic              busy,
    output logic              overrun
);

    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int STEP_W = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam logic [CH_W-1:0]        LAST_CH   = CH_W'(NCH - 1);
    localparam logic [STEP_W-1:0]      LAST_STEP = STEP_W'(ORDER - 1);
    localparam logic signed [ACC_W-1:0] DELTA_A  = ACC_W'(delta(IN_W));

    generate
        if (!params_legal(NCH, IN_W, ACC_W, ORDER)) begin : g_bad_params
            $error("sigma_delta_multich_dac: illegal NCH/IN_W/ACC_W/ORDER combination");
        end
    endgenerate

    state_t                  state, next_state;
    logic [CH_W-1:0]         ch;
    logic [STEP_W-1:0]       step;
    logic                    pending;
    logic [NCH-1:0]          fb_neg;
    logic signed [ACC_W-1:0] captured [NCH];
    logic signed [ACC_W-1:0] work     [NCH];
    logic signed [ACC_W-1:0] pend     [NCH];
    logic signed [ACC_W-1:0] i1       [NCH];
    logic signed [ACC_W-1:0] i2       [NCH];
    logic signed [ACC_W-1:0] op_a, op_b, fb, sum;
    logic                    step_last, frame_last;

    for (genvar k = 0; k < NCH; k++) begin : g_clamp
        sd_dac_clamp #(.IN_W(IN_W), .ACC_W(ACC_W)) u_clamp (
            .sample (sample_in[k*IN_W +: IN_W]),
            .mute   (mute),
            .value  (captured[k])
        );
    end

    // Shared adder: step 0 feeds i1, step 1 cascades the fresh i1 into i2.
    always_comb begin
        step_last  = (step == LAST_STEP);
        frame_last = step_last && (ch == LAST_CH);
        fb         = fb_neg[ch] ? DELTA_A : -DELTA_A;
        if (step == '0) begin
            op_a = i1[ch];
            op_b = work[ch];
        end else begin
            op_a = i2[ch];
            op_b = i1[ch];
        end
        sum = op_a + op_b + fb;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_in_rdy) next_state = RUN;
            RUN:     if (frame_last && !pending && !sample_in_rdy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch      <= '0;
            step    <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            fb_neg  <= '0;
            dout    <= '0;
            for (int k = 0; k < NCH; k++) begin
                i1[k] <= '0;
                i2[k] <= '0;
            end
        end else begin
            overrun <= 1'b0;
            if (state == IDLE) begin
                ch   <= '0;
                step <= '0;
            end else begin
                if (step == '0)
                    i1[ch] <= sum;
                else
                    i2[ch] <= sum;
                if (step_last) begin
                    fb_neg[ch] <= sum[ACC_W-1];
                    dout[ch]   <= ~sum[ACC_W-1];
                    step       <= '0;
                    ch         <= (ch == LAST_CH) ? '0 : ch + 1'b1;
                end else begin
                    step <= step + 1'b1;
                end
                // At the frame boundary the pending slot drains, so a coincident strobe never overruns.
                if (frame_last)
                    pending <= pending && sample_in_rdy;
                else if (sample_in_rdy) begin
                    pending <= 1'b1;
                    overrun <= pending;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (state == IDLE) begin
                if (sample_in_rdy) work[k] <= captured[k];
            end else if (frame_last) begin
                if (pending)
                    work[k] <= pend[k];
                else if (sample_in_rdy)
                    work[k] <= captured[k];
                if (pending && sample_in_rdy)
                    pend[k] <= captured[k];
            end else if (sample_in_rdy) begin
                pend[k] <= captured[k];
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_multich_dac.sv
// Bench for sigma_delta_multich_dac: a 2-channel 2nd-order and a 3-channel
// 1st-order instance checked against a per-frame difference-equation model.
module tb_sigma_delta_multich_dac;

    localparam int     IN_W  = 18;
    localparam int     ACC_W = 48;
    localparam longint DLT   = 64'sd131072;
    localparam longint DLIM  = 64'sd65536;

    logic              clk = 1'b0;
    logic              reset;
    logic [2*IN_W-1:0] sample_in0;
    logic              rdy0, mute0, busy0, overrun0;
    logic [1:0]        dout0;
    logic [3*IN_W-1:0] sample_in1;
    logic              rdy1, mute1, busy1, overrun1;
    logic [2:0]        dout1;

    always #5 clk = ~clk;

    sigma_delta_multich_dac #(.NCH(2), .IN_W(IN_W), .ACC_W(ACC_W), .ORDER(2)) u_dut0 (
        .clk(clk), .reset(reset), .sample_in(sample_in0), .sample_in_rdy(rdy0),
        .mute(mute0), .dout(dout0), .busy(busy0), .overrun(overrun0)
    );

    sigma_delta_multich_dac #(.NCH(3), .IN_W(IN_W), .ACC_W(ACC_W), .ORDER(1)) u_dut1 (
        .clk(clk), .reset(reset), .sample_in(sample_in1), .sample_in_rdy(rdy1),
        .mute(mute1), .dout(dout1), .busy(busy1), .overrun(overrun1)
    );

    int         vectors = 0;
    int         miscompares = 0;
    longint     m_i1 [2][3];
    longint     m_i2 [2][3];
    bit         m_fb [2][3];
    logic [2:0] m_dout [2];

    function automatic int nch_of(input int inst);
        return (inst != 0) ? 3 : 2;
    endfunction

    function automatic int ord_of(input int inst);
        return (inst != 0) ? 1 : 2;
    endfunction

    function automatic longint wrap(input longint x);
        return (x <<< (64 - ACC_W)) >>> (64 - ACC_W);
    endfunction

    function automatic longint ref_clamp(input logic [IN_W-1:0] raw, input logic m);
        longint v;
        v = longint'($signed(raw));
        if (m) return 0;
        if (v >= DLIM) return DLIM;
        if (v < -DLIM) return -DLIM;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dout[i] = '0;
            for (int k = 0; k < 3; k++) begin
                m_i1[i][k] = 0;
                m_i2[i][k] = 0;
                m_fb[i][k] = 1'b0;
            end
        end
    endfunction

    // One whole frame of the modulator difference equations.
    function automatic logic [2:0] model_frame(input int inst, input logic [3*IN_W-1:0] data,
                                               input logic m);
        logic [2:0] out;
        longint     s, f, r;
        out = '0;
        for (int k = 0; k < nch_of(inst); k++) begin
            s = ref_clamp(data[k*IN_W +: IN_W], m);
            f = m_fb[inst][k] ? DLT : -DLT;
            m_i1[inst][k] = wrap(m_i1[inst][k] + s + f);
            if (ord_of(inst) == 2) begin
                m_i2[inst][k] = wrap(m_i2[inst][k] + m_i1[inst][k] + f);
                r = m_i2[inst][k];
            end else begin
                r = m_i1[inst][k];
            end
            m_fb[inst][k] = (r < 0);
            out[k] = (r >= 0);
        end
        m_dout[inst] = out;
        return out;
    endfunction

    function automatic logic [2:0] dout_of(input int inst);
        return (inst != 0) ? dout1 : {1'b0, dout0};
    endfunction

    function automatic logic busy_of(input int inst);
        return (inst != 0) ? busy1 : busy0;
    endfunction

    function automatic logic ovr_of(input int inst);
        return (inst != 0) ? overrun1 : overrun0;
    endfunction

    function automatic logic [3*IN_W-1:0] rand_frame();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[3*IN_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int inst, input logic [3*IN_W-1:0] data, input logic m,
                         input logic r);
        if (inst == 0) begin
            sample_in0 = data[2*IN_W-1:0];
            mute0      = m;
            rdy0       = r;
        end else begin
            sample_in1 = data;
            mute1      = m;
            rdy1       = r;
        end
    endtask

    // Strobe one frame from a negedge, then check every cycle for `waits` cycles.
    task automatic frame(input int inst, input logic [3*IN_W-1:0] data, input logic m,
                         input int waits, input string tag);
        logic [2:0] old_d, new_d, obs_d;
        int         n, o;
        n     = nch_of(inst);
        o     = ord_of(inst);
        old_d = m_dout[inst];
        new_d = model_frame(inst, data, m);
        drive(inst, data, m, 1'b1);
        for (int j = 1; j <= waits; j++) begin
            @(negedge clk);
            if (j == 1) drive(inst, data, m, 1'b0);
            obs_d = dout_of(inst);
            for (int k = 0; k < n; k++)
                chk({tag, "_dout"}, 64'(obs_d[k]),
                    64'(((j - 1) >= (k + 1) * o) ? new_d[k] : old_d[k]));
            chk({tag, "_busy"}, 64'(busy_of(inst)), 64'((j - 1) < n * o));
            chk({tag, "_overrun"}, 64'(ovr_of(inst)), 64'(0));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        chk("reset_dout0", 64'(dout0), 64'(0));
        chk("reset_busy0", 64'(busy0), 64'(0));
        reset = 1'b0;
        @(negedge clk);
    endtask

    logic [1:0]        zero_pat [4];
    logic [2:0]        ord1_pat [4];
    logic [3*IN_W-1:0] fa, fb_d, fc;
    logic [2:0]        exp_a, exp_c, exp_prev;
    int                ones0, ones1;

    initial begin
        zero_pat = '{2'b00, 2'b00, 2'b11, 2'b11};
        ord1_pat = '{3'b000, 3'b111, 3'b111, 3'b111};
        reset = 1'b1;
        drive(0, '0, 1'b0, 1'b0);
        drive(1, '0, 1'b0, 1'b0);
        model_reset();

        // Reset values on both instances.
        repeat (3) @(negedge clk);
        chk("rst_dout0", 64'(dout0), 64'(0));
        chk("rst_busy0", 64'(busy0), 64'(0));
        chk("rst_overrun0", 64'(overrun0), 64'(0));
        chk("rst_dout1", 64'(dout1), 64'(0));
        chk("rst_busy1", 64'(busy1), 64'(0));
        chk("rst_overrun1", 64'(overrun1), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single frame: busy exactly NCH*ORDER cycles.
        frame(0, '0, 1'b0, 5, "busy_len");

        // Zero input gives 0,0,1,1 on every channel.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            frame(0, '0, 1'b0, 8, "zero");
            chk("zero_pattern", 64'(dout0), 64'(zero_pat[i % 4]));
        end

        // First-order, +DELTA/2 on all three channels gives 0,1,1,1.
        for (int i = 0; i < 8; i++) begin
            frame(1, {3{18'h10000}}, 1'b0, 4, "ord1");
            chk("ord1_pattern", 64'(dout1), 64'(ord1_pat[i % 4]));
        end

        // Clamp extremes, strobes back to back so every frame chains.
        do_reset();
        fa    = {18'h0, 18'h20000, 18'h1FFFF};
        ones0 = 0;
        ones1 = 0;
        drive(0, fa, 1'b0, 1'b1);
        exp_prev = '0;
        for (int n = 0; n < 1024; n++) begin
            @(posedge clk);
            @(negedge clk);
            drive(0, fa, 1'b0, 1'b0);
            if (n > 0) begin
                chk("clamp_dout", 64'(dout0), 64'(exp_prev[1:0]));
                chk("clamp_busy", 64'(busy0), 64'(1));
                chk("clamp_overrun", 64'(overrun0), 64'(0));
                ones0 += int'(dout0[0]);
                ones1 += int'(dout0[1]);
            end
            exp_prev = model_frame(0, fa, 1'b0);
            if (n < 1023) begin
                repeat (3) @(negedge clk);
                drive(0, fa, 1'b0, 1'b1);
            end
        end
        repeat (4) @(negedge clk);
        chk("clamp_dout_last", 64'(dout0), 64'(exp_prev[1:0]));
        chk("clamp_busy_end", 64'(busy0), 64'(0));
        ones0 += int'(dout0[0]);
        ones1 += int'(dout0[1]);
        chk("clamp_ones0_in_768pm2", 64'(ones0 >= 766 && ones0 <= 770), 64'(1));
        chk("clamp_ones1_in_256pm2", 64'(ones1 >= 254 && ones1 <= 258), 64'(1));

        // Randomised frames, including clamp regions and mute.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            frame(0, rand_frame(), ($urandom_range(0, 3) == 0), $urandom_range(5, 7), "rand0");
            frame(1, rand_frame(), ($urandom_range(0, 3) == 0), $urandom_range(4, 6), "rand1");
        end

        // Three strobes on consecutive edges: middle frame is dropped.
        do_reset();
        fa    = rand_frame();
        fb_d  = rand_frame();
        fc    = rand_frame();
        exp_a = model_frame(0, fa, 1'b0);
        drive(0, fa, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovr_busy_t0", 64'(busy0), 64'(1));
        chk("ovr_pulse_t0", 64'(overrun0), 64'(0));
        drive(0, fb_d, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovr_pulse_t1", 64'(overrun0), 64'(0));
        drive(0, fc, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovr_pulse_t2", 64'(overrun0), 64'(1));
        chk("ovr_busy_t2", 64'(busy0), 64'(1));
        drive(0, fc, 1'b0, 1'b0);
        exp_c = model_frame(0, fc, 1'b0);
        for (int e = 3; e <= 9; e++) begin
            @(negedge clk);
            chk("ovr_pulse_after", 64'(overrun0), 64'(0));
            chk("ovr_busy", 64'(busy0), 64'(e < 8));
            if (e == 4) chk("ovr_dout_a", 64'(dout0), 64'(exp_a[1:0]));
            if (e == 6) chk("ovr_dout_mix", 64'(dout0), 64'({exp_a[1], exp_c[0]}));
            if (e == 8) chk("ovr_dout_c", 64'(dout0), 64'(exp_c[1:0]));
        end

        // Reset mid-frame with a pending frame queued.
        drive(0, rand_frame(), 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        drive(0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_dout", 64'(dout0), 64'(0));
        chk("midrst_busy", 64'(busy0), 64'(0));
        chk("midrst_overrun", 64'(overrun0), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_pending", 64'(busy0), 64'(0));
        end
        for (int i = 0; i < 4; i++) begin
            frame(0, '0, 1'b0, 8, "midrst_zero");
            chk("midrst_pattern", 64'(dout0), 64'(zero_pat[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sigma_delta_multich_dac.md
# sigma_delta_multich_dac

Parametrised time-multiplexed sigma-delta DAC for the audio output path: accepts one frame of NCH signed PCM samples per sample_in_rdy strobe and drives NCH 1-bit pulse-density outputs. Modulator order (1 or 2), channel count and widths are set by parameters. One shared three-operand adder serves all channels and integrators sequentially. A one-deep pending-frame buffer absorbs a strobe that arrives while a frame is still being processed.

## Interface
- NCH, 2: number of channels, 1..16.
- IN_W, 18: sample width, signed two's complement.
- ACC_W, 48: integrator width, signed; must be ≥ IN_W+4.
- ORDER, 2: modulator order, 1 or 2; any other value is a elaboration error.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high; clock clk.
- sample_in  in  NCH*IN_W  packed frame; channel k occupies bits [k*IN_W +: IN_W].
- sample_in_rdy  in  1  single-cycle frame strobe.
- mute  in  1  sampled together with a frame; when high the frame is treated as all zeros.
- dout  out  NCH  pulse-density outputs; reset 0.
- busy  out  1  high while the engine is processing a frame; reset 0.
- overrun  out  1  one-cycle pulse when a pending frame is overwritten; reset 0.

## Operation
- Constants: D = 2^(IN_W-2) for clamp limit; DELTA = 2^(IN_W-1).
- Capture: the clamp is applied when the frame is stored. Sample bits [IN_W-1:IN_W-2] == 01 give +D, and == 10 give −D; all other values pass unchanged. mute=1 stores 0. The stored value is sign-extended to ACC_W.
- Per-channel state: i1 and i2 (ACC_W, reset 0) and fb_neg (1 bit, reset 0). The feedback value f is +DELTA when fb_neg=1 and −DELTA when fb_neg=0.
- ORDER=2: step 0 computes i1 ← i1 + s + f. Step 1 computes i2 ← i2 + i1_new + f, where i1_new is the value written in step 0.
- ORDER=1: step 0 computes i1 ← i1 + s + f. Here i2 is unused and stays 0.
- Final step of a channel: fb_neg ← sign(result) and dout[k] ← ~sign(result).
- Integrators wrap modulo 2^ACC_W with no saturation. The clamp guarantees no wrap for valid parameters.
- FSM states:
  - IDLE: busy=0. When sample_in_rdy=1, capture the frame into the work registers, set ch=0 and step=0, and go to RUN.
  - RUN: busy=1. Execute (ch, step) once per cycle. step counts 0..ORDER-1; ch then advances 0..NCH-1.
  - After the last (ch, step): if pending=1, move the pending frame into the work registers, clear pending and stay in RUN with ch=0, step=0. Otherwise go to IDLE.
- sample_in_rdy while in RUN: the frame is stored in the pending buffer and pending is set.
  - If pending was already 1, the older pending frame is overwritten and overrun pulses.
  - A strobe on the same edge as the last step is treated as pending and is processed with no IDLE cycle.
- Reset mid-frame: all state returns to reset values immediately and the in-flight frame is discarded.

## Timing
- Edge t0 is the edge that samples sample_in_rdy=1 in IDLE.
- Channel k step j registers at edge t0+1+k*ORDER+j.
- dout[k] updates at edge t0+(k+1)*ORDER.
- busy rises at t0 and stays high for NCH*ORDER cycles; more if a pending frame chains.
- Sustained throughput is one frame per NCH*ORDER cycles. Faster strobes produce overruns.
- Each dout bit holds its value between updates.

## Structure
- Package sd_dac_pkg holds:
  - state encoding (IDLE, RUN);
  - functions delta(IN_W) and clamp_lim(IN_W);
  - the parameter-legality check.
- Sub-module sd_dac_clamp: combinational saturation plus sign-extension of one sample, instantiated NCH times on the capture path.
- The adder, integrator register files (indexed by ch), FSM and pending buffer live in the top module.

## Test plan
- Reset: with reset high, dout=0, busy=0 and overrun=0. Release reset and strobe one frame; busy stays high for exactly NCH*ORDER=4 cycles.
- Zero input, NCH=2, ORDER=2, one strobe per 8 cycles: each dout[k] produces the repeating pattern 0,0,1,1 from the first frame.
- Clamp: ch0=0x1FFFF and ch1=0x20000 (IN_W=18) over 1024 frames. Ones count must be 768±2 for dout[0] and 256±2 for dout[1]. Internal i1 must never wrap.
- ORDER=1, NCH=3, input +DELTA/2 on all channels: each dout shows density 3/4 (pattern 0,1,1,1 from reset). dout[2] updates at t0+3.
- Overrun: three strobes at t0, t0+1 and t0+2 with NCH=2, ORDER=2. overrun pulses once, at t0+2. The third frame is processed right after the first with no IDLE cycle, and busy stays high for 8 cycles.
- Reset at t0+2 mid-frame: dout, integrators and pending all clear. The next strobe then reproduces the zero-input pattern from the second test exactly.
